// File: rtl/regbank_wb_arbiter_if.sv
// regbank_wb_arbiter_if: write-back requests, register bank write port and scoreboard query signals
interface regbank_wb_arbiter_if;
  logic        a_valid;
  logic [3:0]  a_wc;
  logic [31:0] a_data;
  logic        a_ready;
  logic        m_valid;
  logic [3:0]  m_wc;
  logic [31:0] m_data;
  logic        m_ready;
  logic [3:0]  wc;
  logic [31:0] wpc;
  logic        w_rb;
  logic        reserve;
  logic [3:0]  res_wc;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic        stall;
  modport master (
    output a_valid, a_wc, a_data, m_valid, m_wc, m_data, reserve, res_wc, ra, rb,
    input  a_ready, m_ready, wc, wpc, w_rb, stall
  );
  modport slave (
    input  a_valid, a_wc, a_data, m_valid, m_wc, m_data, reserve, res_wc, ra, rb,
    output a_ready, m_ready, wc, wpc, w_rb, stall
  );
endinterface

// File: rtl/regbank_wb_arbiter.sv
// regbank_wb_arbiter: ALU/load write-back arbiter with registered bank write port and busy scoreboard; WB_ROUND_ROBIN_EN selects round-robin over fixed load priority
module regbank_wb_arbiter (
  input logic clk,
  input logic rst_n,
  regbank_wb_arbiter_if.slave bus
);
  logic        pick_m;
  logic        xfer;
  logic [15:0] busy;
  logic [15:0] set_mask;
  logic [15:0] clr_mask;
`ifdef WB_ROUND_ROBIN_EN
  logic last_m;
  // On contention grant whoever did not win the last contended transfer
  always_comb pick_m = (bus.a_valid && bus.m_valid) ? !last_m : bus.m_valid;
  // Pointer moves only on contended transfers; reset means "ALU last"
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_m <= 1'b0;
    else if (bus.a_valid && bus.m_valid) last_m <= pick_m;
`else
  // Loads always win contention
  always_comb pick_m = bus.m_valid;
`endif
  // Combinational grants, forced low while in reset
  always_comb begin
    bus.a_ready = rst_n && bus.a_valid && !pick_m;
    bus.m_ready = rst_n && bus.m_valid && pick_m;
    xfer = bus.a_ready || bus.m_ready;
  end
  // Output stage: one-cycle write pulse, index/data hold when idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.w_rb <= 1'b0;
      bus.wc   <= '0;
      bus.wpc  <= '0;
    end else begin
      bus.w_rb <= xfer;
      if (xfer) begin
        bus.wc  <= pick_m ? bus.m_wc : bus.a_wc;
        bus.wpc <= pick_m ? bus.m_data : bus.a_data;
      end
    end
  // A new claim overrides a same-edge commit of the same index
  always_comb begin
    set_mask = bus.reserve ? 16'h1 << bus.res_wc : 16'h0;
    clr_mask = bus.w_rb ? 16'h1 << bus.wc : 16'h0;
  end
  // Busy scoreboard update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= (busy & ~clr_mask) | set_mask;
  // Hazard on either source; same-cycle claims are not yet visible
  always_comb bus.stall = busy[bus.ra] || busy[bus.rb];
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// tb_regbank_wb_arbiter: directed stimulus with a write-back scoreboard checked by a separate monitor
module tb_regbank_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [35:0] q[$];
  regbank_wb_arbiter_if bus();
  regbank_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic idle();
    bus.a_valid = 1'b0;
    bus.m_valid = 1'b0;
    bus.reserve = 1'b0;
  endtask
  task automatic push(input logic [3:0] w, input logic [31:0] d);
    q.push_back({w, d});
  endtask
  // Monitor: every bank write must match the next expected write-back
  initial forever begin
    @(negedge clk);
    if (bus.w_rb === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wc=%h wpc=%h expected no write", bus.wc, bus.wpc);
      end else begin
        logic [35:0] e;
        e = q.pop_front();
        chk("wb_wc", {28'h0, bus.wc}, {28'h0, e[35:32]});
        chk("wb_wpc", bus.wpc, e[31:0]);
      end
    end
  end
  // Watchdog
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    logic exp_m;
    rst_n = 1'b1;
    idle();
    bus.a_wc = '0; bus.a_data = '0; bus.m_wc = '0; bus.m_data = '0;
    bus.res_wc = '0; bus.ra = '0; bus.rb = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_w_rb", bus.w_rb, 0);
    chk("rst_wc", bus.wc, 0);
    chk("rst_wpc", bus.wpc, 0);
    chk("rst_stall", bus.stall, 0);
    bus.a_valid = 1'b1; bus.m_valid = 1'b1;
    #1;
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_m_ready", bus.m_ready, 0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // Lone ALU request
    @(negedge clk); #1;
    bus.a_valid = 1'b1; bus.a_wc = 4'd3; bus.a_data = 32'h1234;
    #1;
    chk("solo_a_ready", bus.a_ready, 1);
    chk("solo_m_ready", bus.m_ready, 0);
    push(4'd3, 32'h1234);
    @(negedge clk); #1;
    idle();
    chk("solo_w_rb_on", bus.w_rb, 1);
    @(negedge clk); #1;
    chk("solo_w_rb_off", bus.w_rb, 0);
    // Contention for four cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      bus.a_valid = 1'b1; bus.a_wc = 4'd1; bus.a_data = 32'hA1;
      bus.m_valid = 1'b1; bus.m_wc = 4'd2; bus.m_data = 32'hB2;
      #1;
`ifdef WB_ROUND_ROBIN_EN
      exp_m = (i % 2 == 0);
`else
      exp_m = 1'b1;
`endif
      chk("cont_a_ready", bus.a_ready, !exp_m);
      chk("cont_m_ready", bus.m_ready, exp_m);
      if (exp_m) push(4'd2, 32'hB2);
      else push(4'd1, 32'hA1);
    end
    @(negedge clk); #1;
    idle();
    // Reserve 5, then a load to 5 clears it
    @(negedge clk); #1;
    bus.reserve = 1'b1; bus.res_wc = 4'd5; bus.ra = 4'd5; bus.rb = 4'd0;
    #1;
    chk("res5_same_cycle_stall", bus.stall, 0);
    @(negedge clk); #1;
    bus.reserve = 1'b0;
    #1;
    chk("res5_stall", bus.stall, 1);
    bus.rb = 4'd5;
    #1;
    chk("res5_ra_eq_rb_stall", bus.stall, 1);
    bus.m_valid = 1'b1; bus.m_wc = 4'd5; bus.m_data = 32'h55;
    #1;
    chk("res5_m_ready", bus.m_ready, 1);
    push(4'd5, 32'h55);
    @(negedge clk); #1;
    idle();
    chk("res5_stall_during_wb", bus.stall, 1);
    @(negedge clk); #1;
    chk("res5_stall_cleared", bus.stall, 0);
    // Claim 7 again on the same edge its write commits
    bus.reserve = 1'b1; bus.res_wc = 4'd7; bus.ra = 4'd0; bus.rb = 4'd7;
    bus.a_valid = 1'b1; bus.a_wc = 4'd7; bus.a_data = 32'h77;
    #1;
    chk("res7_a_ready", bus.a_ready, 1);
    push(4'd7, 32'h77);
    @(negedge clk); #1;
    bus.a_valid = 1'b0;
    #1;
    chk("res7_stall_before", bus.stall, 1);
    @(negedge clk); #1;
    bus.reserve = 1'b0;
    #1;
    chk("res7_set_wins", bus.stall, 1);
    // Write to a non-busy index leaves busy alone
    bus.a_valid = 1'b1; bus.a_wc = 4'd9; bus.a_data = 32'h99;
    #1;
    chk("nb9_a_ready", bus.a_ready, 1);
    push(4'd9, 32'h99);
    @(negedge clk); #1;
    idle();
    @(negedge clk); #1;
    chk("nb9_busy7_kept", bus.stall, 1);
    bus.ra = 4'd9; bus.rb = 4'd9;
    #1;
    chk("nb9_not_busy", bus.stall, 0);
    // Fill busy to 0x00FF with a write to 12 in flight, then reset
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      bus.reserve = 1'b1; bus.res_wc = i[3:0];
      if (i == 7) begin
        bus.a_valid = 1'b1; bus.a_wc = 4'd12; bus.a_data = 32'hCC;
        #1;
        chk("rst_mid_a_ready", bus.a_ready, 1);
        push(4'd12, 32'hCC);
      end
    end
    @(negedge clk); #1;
    idle();
    bus.ra = 4'd3; bus.rb = 4'd3;
    #1;
    chk("rst_mid_w_rb_before", bus.w_rb, 1);
    chk("rst_mid_stall_before", bus.stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_w_rb", bus.w_rb, 0);
    chk("rst_mid_wc", bus.wc, 0);
    chk("rst_mid_wpc", bus.wpc, 0);
    chk("rst_mid_stall3", bus.stall, 0);
    bus.ra = 4'd0; bus.rb = 4'd7;
    bus.a_valid = 1'b1;
    #1;
    chk("rst_mid_stall07", bus.stall, 0);
    chk("rst_mid_a_ready", bus.a_ready, 0);
    bus.a_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_release_w_rb", bus.w_rb, 0);
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regbank_wb_arbiter.md
REGBANK_WB_ARBITER -- requirements
Module: regbank_wb_arbiter

Interface
REQ-001 Parameters: none; all widths fixed (16 registers, 4-bit index, 32-bit data).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 A_VALID  input  1  ALU write-back request.
REQ-005 A_WC  input  4  ALU destination register index.
REQ-006 A_DATA  input  32  ALU write data.
REQ-007 A_READY  output  1  ALU request accepted this cycle.
REQ-008 M_VALID  input  1  memory-load write-back request.
REQ-009 M_WC  input  4  load destination register index.
REQ-010 M_DATA  input  32  load write data.
REQ-011 M_READY  output  1  load request accepted this cycle.
REQ-012 WC  output  4  register bank write index (registered).
REQ-013 WPC  output  32  register bank write data (registered).
REQ-014 W_RB  output  1  register bank write enable (registered).
REQ-015 RESERVE  input  1  issue stage claims a destination register.
REQ-016 RES_WC  input  4  index claimed by RESERVE.
REQ-017 RA, RB  input  4 each  source indices being read by the issue stage.
REQ-018 STALL  output  1  a source register has a pending write.

Function
REQ-019 A request transfers on a rising edge where VALID=1 and READY=1; VALID, WC and DATA hold stable until transfer.
REQ-020 READY is combinational: a requester whose VALID=1 and which wins arbitration gets READY=1; the loser gets READY=0; READY=0 whenever VALID=0.
REQ-021 A sole valid requester always wins; no idle bubble inserted.
REQ-022 On a transfer edge, WC/WPC load the winner's index/data and W_RB becomes 1; with no transfer, W_RB becomes 0 and WC/WPC hold.
REQ-023 Latency: accepted at edge N, W_RB=1 for exactly the cycle N to N+1, register bank written at edge N+1; back-to-back transfers sustain one write per cycle.
REQ-024 Scoreboard: 16-bit busy vector; RESERVE=1 at an edge sets busy[RES_WC].
REQ-025 A write leaving the output stage (W_RB=1 at an edge) clears busy[WC].
REQ-026 Same edge set and clear of the same index: set wins (newer producer pending).
REQ-027 Writes to non-busy indices are legal and leave busy unchanged.
REQ-028 STALL = busy[RA] OR busy[RB], combinational; RA=RB counts once.
REQ-029 STALL ignores RESERVE in the same cycle (claim visible from the following cycle).

Reset
REQ-030 RST_N=0 asynchronously forces W_RB=0, WC=0, WPC=0, busy=0, round-robin pointer to "ALU last"; hence STALL=0.
REQ-031 Reset mid-transfer discards the in-flight write; W_RB never pulses on the reset-release edge.
REQ-032 While RST_N=0, A_READY=M_READY=0.

Configuration
REQ-033 Macro WB_ROUND_ROBIN_EN: when defined, contention (both VALID=1) is granted to the requester not granted at the last contended transfer; pointer updates only on contended transfers.
REQ-034 Without WB_ROUND_ROBIN_EN: fixed priority, memory load always wins contention; no pointer state exists.

Verification
REQ-035 A_VALID=1, A_WC=3, A_DATA=0x1234 alone -> A_READY=1; next cycle W_RB=1, WC=3, WPC=0x1234; following cycle W_RB=0.
REQ-036 Both valid (A_WC=1, M_WC=2) for 4 cycles, macro defined -> grants M,A,M,A (after reset pointer "ALU last"); undefined -> M every cycle, A_READY=0 throughout.
REQ-037 RESERVE=1, RES_WC=5; next cycle RA=5 -> STALL=1; M write to 5 accepted -> STALL drops the cycle after W_RB=1 for WC=5.
REQ-038 RESERVE on index 7 at the same edge W_RB=1 commits index 7 -> busy[7] remains 1, STALL=1 for RB=7.
REQ-039 RST_N pulsed low mid-cycle while W_RB=1 and busy=0x00FF -> W_RB, WC, WPC, busy all 0 immediately, before the next edge.
